ddr_read_tracker: RTL and testbench
===================================

# ddr_read_tracker

Credit-gated read tracker between the ORAM backend command/address path and the DRAM model or controller. It forwards commands downstream and records the address of every accepted read in order. It also captures returned read data, which cannot be backpressured, into a local buffer sized so that it can never overflow. Each returned beat is presented upstream paired with its originating address. This replaces the ad-hoc address FIFO and the "lost read data" check in backend benches, and it is synthesizable for hardware DRAM paths.

## Interface
- AWidth, 28: DRAM address width.
- DWidth, 512: DRAM data beat width.
- Depth, 16: maximum outstanding reads, which is also the buffer depth. Must be a power of two, 2 to 1024.
- CntWidth, clog2(Depth+1): width of the credit and occupancy counters.

- Clock  in  1  clock.
- Reset  in  1  reset Reset, synchronous, active-low.
- CmdAddress  in  AWidth  command address from the backend.
- CmdIsRead  in  1  1 = read, 0 = write.
- CmdValid  in  1  backend command valid.
- CmdReady  out  1  command accepted.
- DRAMCmdAddress  out  AWidth  equals CmdAddress.
- DRAMCmdIsRead  out  1  equals CmdIsRead.
- DRAMCmdValid  out  1  forwarded command valid.
- DRAMCmdReady  in  1  DRAM accepts the command.
- DRAMDataIn  in  DWidth  returned read beat.
- DRAMDataValid  in  1  returned beat valid. There is no ready signal; every beat is consumed.
- OutData  out  DWidth  beat presented to the backend.
- OutAddress  out  AWidth  address of the read that produced OutData.
- OutValid  out  1  paired beat available.
- OutReady  in  1  backend consumes the beat.
- Outstanding  out  CntWidth  reads issued and not yet consumed at Out.
- Error  out  1  sticky: a beat arrived with no read pending.
- MaxOutstanding  out  CntWidth  high-water mark of Outstanding. Stats only; see Configuration.
- ReadsDone  out  32  count of consumed beats. Stats only; see Configuration.

## Operation
- Gate = !Error && (!CmdIsRead || Outstanding < Depth).
- DRAMCmdValid = CmdValid && Gate.
- CmdReady = DRAMCmdReady && Gate.
- Both are combinational; there is no command register.
- A read is issued when CmdValid && CmdReady && CmdIsRead.
- Address FIFO (Depth x AWidth): pushed with CmdAddress on read issue. Popped on an Out handshake.
- Data FIFO (Depth x DWidth): pushed on DRAMDataValid.
  - Returned = data FIFO occupancy plus beats already consumed. Tracked via counter Pending = issued minus returned.
  - If DRAMDataValid arrives while Pending == 0, the beat is dropped, not pushed, and Error sets.
- Out is valid when the data FIFO is non-empty. OutData is the data FIFO head; OutAddress is the address FIFO head. Order is strictly FIFO; DRAM returns in order.
- Outstanding:
  - +1 on read issue, −1 on Out handshake, unchanged when both occur in the same cycle.
  - It can never exceed Depth, so the data FIFO never overflows.
- Pending:
  - +1 on issue, −1 on an accepted DRAM beat.
  - Simultaneous issue and beat leaves it unchanged.
- Error is cleared only by Reset. While Error is set:
  - All commands are blocked.
  - Buffered beats still drain at Out.
- Writes pass through ungated except by Error. They do not affect any counter.

## Timing
- Reset (Reset == 0 at a clock edge) clears both FIFOs and all counters. Error = 0, MaxOutstanding = 0, ReadsDone = 0.
- While Reset == 0: OutValid = 0, CmdReady = 0, DRAMCmdValid = 0.
- Reset mid-operation discards all in-flight state. Beats arriving after reset with Pending == 0 set Error.
- Latency: a beat at DRAMDataValid in cycle N gives OutValid in cycle N+1 (registered FIFO). It stays presented until OutReady.
- Back-to-back throughput is 1 beat per cycle at Out when OutReady is held at 1.
- Full boundary: with Outstanding == Depth, a read is blocked (CmdReady = 0) even if an Out handshake occurs in the same cycle. The credit becomes visible the next cycle.
- Empty boundary: a beat and an Out pop cannot collide on an empty FIFO, because OutValid requires a registered entry.
- Pointers wrap modulo Depth.

## Configuration
- RDTRACK_STATS_EN defined:
  - MaxOutstanding updates to max(MaxOutstanding, next Outstanding) each cycle.
  - ReadsDone increments on each Out handshake and wraps at 2^32.
- Not defined: MaxOutstanding and ReadsDone are tied to 0, and their logic is omitted.

## Test plan
Benches use Depth = 4.
- **Single read:** issue a read to 0x100, return beat 0xAB after 30 cycles, OutReady = 1. Expect OutValid one cycle later with OutAddress = 0x100 and OutData = 0xAB, then Outstanding returns to 0.
- **Credit limit:** issue 5 reads (0x0–0x4) with OutReady = 0. Expect 4 accepted, the 5th held with CmdReady = 0 and Outstanding = 4. One Out handshake releases the 5th on the next cycle.
- **Ordering under stalls:** issue 4 reads and return 4 beats back-to-back, with OutReady toggling 1,0,1,0. Expect address/data pairs in issue order and no loss.
- **Writes bypass:** issue interleaved writes at Outstanding = 4. Expect writes forwarded while reads stay blocked and Outstanding stays at 4.
- **Spurious beat:** DRAMDataValid with nothing issued. Expect Error = 1 next cycle, no OutValid, and all further commands blocked until Reset.
- **Stats (RDTRACK_STATS_EN):** run the credit-limit scenario, then drain. Expect MaxOutstanding = 4 and ReadsDone = 5.

Source files
------------

// File: rtl/ddr_read_tracker.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_read_tracker: credit-gated DRAM read tracker pairing returned beats     |
// | with their read addresses. Optional statistics under RDTRACK_STATS_EN.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ddr_read_tracker #(
  parameter int AWidth   = 28,
  parameter int DWidth   = 512,
  parameter int Depth    = 16,
  parameter int CntWidth = $clog2(Depth + 1)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [AWidth-1:0]   CmdAddress,
  input  logic                CmdIsRead,
  input  logic                CmdValid,
  output logic                CmdReady,
  output logic [AWidth-1:0]   DRAMCmdAddress,
  output logic                DRAMCmdIsRead,
  output logic                DRAMCmdValid,
  input  logic                DRAMCmdReady,
  input  logic [DWidth-1:0]   DRAMDataIn,
  input  logic                DRAMDataValid,
  output logic [DWidth-1:0]   OutData,
  output logic [AWidth-1:0]   OutAddress,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [CntWidth-1:0] Outstanding,
  output logic                Error,
  output logic [CntWidth-1:0] MaxOutstanding,
  output logic [31:0]         ReadsDone
);

  localparam int                PTR_W     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] DEPTH_CNT = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] CNT_ONE   = CntWidth'(1);
  localparam logic [CntWidth-1:0] CNT_ZERO  = '0;
  localparam logic [PTR_W-1:0]    PTR_ONE   = PTR_W'(1);

  logic [CntWidth-1:0] outstanding_q, outstanding_next;
  logic [CntWidth-1:0] pending_q, pending_next;
  logic [CntWidth-1:0] data_count_q, data_count_next;
  logic                error_q;

  logic [PTR_W-1:0]    addr_wr_ptr, addr_rd_ptr;
  logic [PTR_W-1:0]    data_wr_ptr, data_rd_ptr;
  logic [AWidth-1:0]   addr_mem [Depth];
  logic [DWidth-1:0]   data_mem [Depth];

  logic gate;
  logic cmd_open;
  logic read_issue;
  logic beat_accept;
  logic beat_spurious;
  logic out_pop;

  // Commands are combinationally gated; a full tracker only blocks reads.
  assign gate     = !error_q && (!CmdIsRead || (outstanding_q < DEPTH_CNT));
  assign cmd_open = Reset && gate;

  assign DRAMCmdAddress = CmdAddress;
  assign DRAMCmdIsRead  = CmdIsRead;
  assign DRAMCmdValid   = CmdValid && cmd_open;
  assign CmdReady       = DRAMCmdReady && cmd_open;

  assign read_issue    = CmdValid && CmdReady && CmdIsRead;
  assign beat_accept   = Reset && DRAMDataValid && (pending_q != CNT_ZERO);
  assign beat_spurious = Reset && DRAMDataValid && (pending_q == CNT_ZERO);

  assign OutValid   = Reset && (data_count_q != CNT_ZERO);
  assign out_pop    = OutValid && OutReady;
  assign OutData    = data_mem[data_rd_ptr];
  assign OutAddress = addr_mem[addr_rd_ptr];

  assign Outstanding = outstanding_q;
  assign Error       = error_q;

  always_comb begin
    outstanding_next = outstanding_q;
    pending_next     = pending_q;
    data_count_next  = data_count_q;

    case ({read_issue, out_pop})
      2'b10:   outstanding_next = outstanding_q + CNT_ONE;
      2'b01:   outstanding_next = outstanding_q - CNT_ONE;
      default: outstanding_next = outstanding_q;
    endcase

    case ({read_issue, beat_accept})
      2'b10:   pending_next = pending_q + CNT_ONE;
      2'b01:   pending_next = pending_q - CNT_ONE;
      default: pending_next = pending_q;
    endcase

    case ({beat_accept, out_pop})
      2'b10:   data_count_next = data_count_q + CNT_ONE;
      2'b01:   data_count_next = data_count_q - CNT_ONE;
      default: data_count_next = data_count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      outstanding_q <= '0;
      pending_q     <= '0;
      data_count_q  <= '0;
      error_q       <= 1'b0;
      addr_wr_ptr   <= '0;
      addr_rd_ptr   <= '0;
      data_wr_ptr   <= '0;
      data_rd_ptr   <= '0;
    end else begin
      outstanding_q <= outstanding_next;
      pending_q     <= pending_next;
      data_count_q  <= data_count_next;
      if (beat_spurious) begin
        error_q <= 1'b1;
      end
      if (read_issue) begin
        addr_wr_ptr <= addr_wr_ptr + PTR_ONE;
      end
      if (beat_accept) begin
        data_wr_ptr <= data_wr_ptr + PTR_ONE;
      end
      // Both FIFOs pop together: every presented beat owns one address entry.
      if (out_pop) begin
        addr_rd_ptr <= addr_rd_ptr + PTR_ONE;
        data_rd_ptr <= data_rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge Clock) begin
    if (read_issue) begin
      addr_mem[addr_wr_ptr] <= CmdAddress;
    end
    if (beat_accept) begin
      data_mem[data_wr_ptr] <= DRAMDataIn;
    end
  end

`ifdef RDTRACK_STATS_EN
  logic [CntWidth-1:0] max_outstanding_q;
  logic [31:0]         reads_done_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      max_outstanding_q <= '0;
      reads_done_q      <= '0;
    end else begin
      if (outstanding_next > max_outstanding_q) begin
        max_outstanding_q <= outstanding_next;
      end
      if (out_pop) begin
        reads_done_q <= reads_done_q + 32'd1;
      end
    end
  end

  assign MaxOutstanding = max_outstanding_q;
  assign ReadsDone      = reads_done_q;
`else
  assign MaxOutstanding = '0;
  assign ReadsDone      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_read_tracker.sv
`timescale 1ns / 1ps
`default_nettype none
// Self-checking bench for ddr_read_tracker (Depth = 4) using an address/data scoreboard.
module tb_ddr_read_tracker;

  localparam int AW    = 28;
  localparam int DW    = 512;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [AW-1:0] CmdAddress = '0;
  logic          CmdIsRead = 1'b0;
  logic          CmdValid = 1'b0;
  logic          CmdReady;
  logic [AW-1:0] DRAMCmdAddress;
  logic          DRAMCmdIsRead;
  logic          DRAMCmdValid;
  logic          DRAMCmdReady = 1'b1;
  logic [DW-1:0] DRAMDataIn = '0;
  logic          DRAMDataValid = 1'b0;
  logic [DW-1:0] OutData;
  logic [AW-1:0] OutAddress;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [CW-1:0] Outstanding;
  logic          Error;
  logic [CW-1:0] MaxOutstanding;
  logic [31:0]   ReadsDone;

  ddr_read_tracker #(
    .AWidth(AW), .DWidth(DW), .Depth(DEPTH), .CntWidth(CW)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .CmdAddress(CmdAddress), .CmdIsRead(CmdIsRead), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .DRAMCmdAddress(DRAMCmdAddress), .DRAMCmdIsRead(DRAMCmdIsRead),
    .DRAMCmdValid(DRAMCmdValid), .DRAMCmdReady(DRAMCmdReady),
    .DRAMDataIn(DRAMDataIn), .DRAMDataValid(DRAMDataValid),
    .OutData(OutData), .OutAddress(OutAddress), .OutValid(OutValid), .OutReady(OutReady),
    .Outstanding(Outstanding), .Error(Error),
    .MaxOutstanding(MaxOutstanding), .ReadsDone(ReadsDone)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         sb[$];
  logic [AW-1:0] exp_addr[$];
  beat_t         mon_exp;
  int            n_cmp  = 0;
  int            n_fail = 0;

  // Every Out handshake is checked against the scoreboard head.
  always @(negedge Clock) begin
    if (Reset && OutValid && OutReady) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got addr %h with no beat expected", OutAddress);
      end else begin
        mon_exp = sb.pop_front();
        if (OutAddress !== mon_exp.addr || OutData !== mon_exp.data) begin
          n_fail++;
          $display("FAIL out_pair: got addr %h data %h, expected addr %h data %h",
                   OutAddress, OutData, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset         = 1'b0;
    CmdValid      = 1'b0;
    DRAMDataValid = 1'b0;
    OutReady      = 1'b0;
    DRAMCmdReady  = 1'b1;
    tick();
    tick();
    Reset = 1'b1;
    sb.delete();
    exp_addr.delete();
  endtask

  task automatic issue_read(input logic [AW-1:0] addr);
    int waited = 0;
    CmdAddress = addr;
    CmdIsRead  = 1'b1;
    CmdValid   = 1'b1;
    #1;
    while (!CmdReady && waited < 50) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (waited >= 50) begin
      n_fail++;
      $display("FAIL issue_timeout: read %h not accepted, waited %0d cycles, required < 50", addr, waited);
    end
    tick();
    CmdValid = 1'b0;
    exp_addr.push_back(addr);
  endtask

  task automatic send_beat(input logic [DW-1:0] data);
    beat_t b;
    DRAMDataValid = 1'b1;
    DRAMDataIn    = data;
    if (exp_addr.size() > 0) begin
      b.addr = exp_addr.pop_front();
      b.data = data;
      sb.push_back(b);
    end
    tick();
    DRAMDataValid = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    OutReady = 1'b1;
    while (sb.size() > 0 && n < 40) begin
      tick();
      if (toggle) OutReady = ~OutReady;
      n++;
    end
    OutReady = 1'b0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats left, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    Reset     = 1'b0;
    CmdValid  = 1'b1;
    CmdIsRead = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (CmdReady !== 1'b0 || DRAMCmdValid !== 1'b0 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: CmdReady %b DRAMCmdValid %b OutValid %b, required 0 0 0",
               CmdReady, DRAMCmdValid, OutValid);
    end
    Reset = 1'b1;
    #1;
    n_cmp++;
    if (Outstanding !== '0 || Error !== 1'b0 || MaxOutstanding !== '0 || ReadsDone !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: Outstanding %0d Error %b Max %0d Done %0d, required 0 0 0 0",
               Outstanding, Error, MaxOutstanding, ReadsDone);
    end
    n_cmp++;
    if (CmdReady !== 1'b1 || DRAMCmdValid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: CmdReady %b DRAMCmdValid %b, required 1 1", CmdReady, DRAMCmdValid);
    end
    CmdValid = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    OutReady = 1'b1;
    issue_read(28'h100);
    n_cmp++;
    if (Outstanding !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_outstanding: got %0d, required 1", Outstanding);
    end
    repeat (29) tick();
    n_cmp++;
    if (OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid: OutValid %b, required 0", OutValid);
    end
    send_beat(512'hAB);
    n_cmp++;
    if (OutValid !== 1'b1 || OutAddress !== 28'h100 || OutData !== 512'hAB) begin
      n_fail++;
      $display("FAIL single_latency: OutValid %b addr %h data %h, required 1 100 ab",
               OutValid, OutAddress, OutData);
    end
    tick();
    n_cmp++;
    if (Outstanding !== '0 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: Outstanding %0d OutValid %b, required 0 0", Outstanding, OutValid);
    end
    OutReady = 1'b0;
  endtask

  task automatic test_credit_limit();
    do_reset();
    for (int i = 0; i < 4; i++) issue_read(AW'(i));
    n_cmp++;
    if (Outstanding !== CW'(4)) begin
      n_fail++;
      $display("FAIL credit_full: Outstanding %0d, required 4", Outstanding);
    end
    CmdAddress = 28'h4;
    CmdIsRead  = 1'b1;
    CmdValid   = 1'b1;
    #1;
    n_cmp++;
    if (CmdReady !== 1'b0 || DRAMCmdValid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_block: CmdReady %b DRAMCmdValid %b, required 0 0", CmdReady, DRAMCmdValid);
    end
    for (int i = 0; i < 4; i++) send_beat(DW'(32'hC0DE_0000 + i));
    OutReady = 1'b1;
    #1;
    n_cmp++;
    if (CmdReady !== 1'b0 || OutValid !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_same_cycle: CmdReady %b OutValid %b, required 0 1", CmdReady, OutValid);
    end
    tick();
    OutReady = 1'b0;
    #1;
    n_cmp++;
    if (CmdReady !== 1'b1 || Outstanding !== CW'(3)) begin
      n_fail++;
      $display("FAIL credit_release: CmdReady %b Outstanding %0d, required 1 3", CmdReady, Outstanding);
    end
    tick();
    CmdValid = 1'b0;
    exp_addr.push_back(28'h4);
    n_cmp++;
    if (Outstanding !== CW'(4)) begin
      n_fail++;
      $display("FAIL credit_fifth: Outstanding %0d, required 4", Outstanding);
    end
    send_beat(512'h55);
    drain(1'b0);
    n_cmp++;
    if (Outstanding !== '0) begin
      n_fail++;
      $display("FAIL credit_drained: Outstanding %0d, required 0", Outstanding);
    end
    n_cmp++;
`ifdef RDTRACK_STATS_EN
    if (MaxOutstanding !== CW'(4) || ReadsDone !== 32'd5) begin
      n_fail++;
      $display("FAIL stats: Max %0d Done %0d, required 4 5", MaxOutstanding, ReadsDone);
    end
`else
    if (MaxOutstanding !== '0 || ReadsDone !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_tied: Max %0d Done %0d, required 0 0", MaxOutstanding, ReadsDone);
    end
`endif
  endtask

  task automatic test_ordering();
    beat_t b;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) issue_read(AW'(28'h200 + 16 * i));
    for (int i = 0; i < 4; i++) begin
      d = {16{$urandom()}};
      DRAMDataValid = 1'b1;
      DRAMDataIn    = d;
      b.addr = exp_addr.pop_front();
      b.data = d;
      sb.push_back(b);
      OutReady = (i % 2 == 0);
      tick();
    end
    DRAMDataValid = 1'b0;
    drain(1'b1);
    n_cmp++;
    if (Outstanding !== '0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL order_done: Outstanding %0d Error %b, required 0 0", Outstanding, Error);
    end
  endtask

  task automatic test_writes_bypass();
    logic [AW-1:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) issue_read(AW'(28'h300 + i));
    for (int i = 0; i < 6; i++) begin
      a          = AW'(28'h3A0 + i);
      CmdAddress = a;
      CmdIsRead  = i[0];
      CmdValid   = 1'b1;
      #1;
      n_cmp++;
      if (i[0]) begin
        if (CmdReady !== 1'b0 || DRAMCmdValid !== 1'b0) begin
          n_fail++;
          $display("FAIL bypass_read_blocked: CmdReady %b DRAMCmdValid %b, required 0 0", CmdReady, DRAMCmdValid);
        end
      end else begin
        if (CmdReady !== 1'b1 || DRAMCmdValid !== 1'b1 || DRAMCmdAddress !== a || DRAMCmdIsRead !== 1'b0) begin
          n_fail++;
          $display("FAIL bypass_write: CmdReady %b DRAMCmdValid %b addr %h, required 1 1 %h",
                   CmdReady, DRAMCmdValid, DRAMCmdAddress, a);
        end
      end
      tick();
      n_cmp++;
      if (Outstanding !== CW'(4)) begin
        n_fail++;
        $display("FAIL bypass_outstanding: got %0d, required 4", Outstanding);
      end
    end
    CmdIsRead    = 1'b0;
    DRAMCmdReady = 1'b0;
    #1;
    n_cmp++;
    if (CmdReady !== 1'b0 || DRAMCmdValid !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_backpressure: CmdReady %b DRAMCmdValid %b, required 0 1", CmdReady, DRAMCmdValid);
    end
    CmdValid     = 1'b0;
    DRAMCmdReady = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(DW'(32'hBEEF_0000 + i));
    drain(1'b0);
  endtask

  task automatic test_spurious();
    do_reset();
    issue_read(28'h40);
    issue_read(28'h41);
    do_reset();
    OutReady      = 1'b1;
    DRAMDataValid = 1'b1;
    DRAMDataIn    = 512'hDEAD;
    #1;
    n_cmp++;
    if (Error !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_early: Error %b, required 0", Error);
    end
    tick();
    DRAMDataValid = 1'b0;
    n_cmp++;
    if (Error !== 1'b1 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_error: Error %b OutValid %b, required 1 0", Error, OutValid);
    end
    for (int i = 0; i < 2; i++) begin
      CmdIsRead = i[0];
      CmdValid  = 1'b1;
      tick();
      n_cmp++;
      if (CmdReady !== 1'b0 || DRAMCmdValid !== 1'b0 || Error !== 1'b1 || Outstanding !== '0) begin
        n_fail++;
        $display("FAIL spurious_blocked: CmdReady %b DRAMCmdValid %b Error %b Outstanding %0d, required 0 0 1 0",
                 CmdReady, DRAMCmdValid, Error, Outstanding);
      end
    end
    do_reset();
    n_cmp++;
    if (Error !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_cleared: Error %b, required 0", Error);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_credit_limit();
    test_ordering();
    test_writes_bypass();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
